// File: rtl/ic_bvsle_bvudiv_witness_checker_if.sv
// Request/result bundle for the bvsle/bvudiv witness checker.
// Request side: in_valid/in_ready handshake carrying op_sel, x, s, t.
// Result side: out_valid/out_ready handshake carrying q, holds, div_zero.
// pass_cnt/fail_cnt are free-running status outputs of the checker.
// The "slave" modport is the checker, the "master" modport is the source/sink.
interface ic_bvsle_bvudiv_witness_checker_if #(
  parameter int W     = 4,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sel;
  logic [W-1:0]     x;
  logic [W-1:0]     s;
  logic [W-1:0]     t;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     q;
  logic             holds;
  logic             div_zero;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

  modport master (
    output in_valid, op_sel, x, s, t, out_ready,
    input  in_ready, out_valid, q, holds, div_zero, pass_cnt, fail_cnt
  );

  modport slave (
    input  in_valid, op_sel, x, s, t, out_ready,
    output in_ready, out_valid, q, holds, div_zero, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/ic_bvsle_bvudiv_witness_checker.sv
// Sequential checker for Skolem-function witnesses of the bvsle/bvudiv
// invertibility condition. A candidate x with operands s and t is accepted,
// the unsigned quotient (x udiv s, or s udiv x when op_sel=1) is produced by a
// bit-serial restoring divider, and the signed comparison q <=s t is reported.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - slave side of ic_bvsle_bvudiv_witness_checker_if (request and
//            result handshakes plus saturating pass/fail counters)
module ic_bvsle_bvudiv_witness_checker #(
  parameter int W     = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  ic_bvsle_bvudiv_witness_checker_if.slave bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t           r_state;
  logic [W-1:0]     r_dividend;
  logic [W-1:0]     r_divisor;
  logic [W-1:0]     r_t;
  logic [W-1:0]     r_rem;
  logic [W-1:0]     r_quot;
  logic [CW-1:0]    r_bitCnt;
  logic             r_inReady;
  logic             r_outValid;
  logic [W-1:0]     r_q;
  logic             r_holds;
  logic             r_divZero;
  logic [CNT_W-1:0] r_passCnt;
  logic [CNT_W-1:0] r_failCnt;

  logic [W:0]       w_remShift;
  logic             w_ge;
  logic [W-1:0]     w_remSub;
  logic [W-1:0]     w_remNext;
  logic [W-1:0]     w_quotNext;
  logic [W-1:0]     w_allOnes;
  logic             w_holdsNext;
  logic             w_holdsZero;

  // One restoring step. The stored remainder is always below the divisor, so
  // it fits in W bits; only the shifted partial remainder needs the extra bit.
  // The subtraction is done in W bits because its result is also < divisor.
  assign w_remShift  = {r_rem, r_dividend[r_bitCnt]};
  assign w_ge        = (w_remShift >= {1'b0, r_divisor});
  assign w_remSub    = w_remShift[W-1:0] - r_divisor;
  assign w_remNext   = w_ge ? w_remSub : w_remShift[W-1:0];
  assign w_quotNext  = r_quot | (W'(w_ge) << r_bitCnt);

  // Division by zero yields all ones (SMT-LIB bvudiv), i.e. -1 when signed.
  assign w_allOnes   = {W{1'b1}};
  assign w_holdsNext = ($signed(w_quotNext) <= $signed(r_t));
  assign w_holdsZero = ($signed(w_allOnes) <= $signed(r_t));

  // Control FSM and datapath. All outputs are registered; the result fields
  // are captured once on entry to DONE so they stay stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_t        <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_bitCnt   <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_q        <= '0;
      r_holds    <= 1'b0;
      r_divZero  <= 1'b0;
      r_passCnt  <= '0;
      r_failCnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_dividend <= bus.op_sel ? bus.s : bus.x;
            r_divisor  <= bus.op_sel ? bus.x : bus.s;
            r_t        <= bus.t;
            r_rem      <= '0;
            r_quot     <= '0;
            r_bitCnt   <= LAST_BIT;
            r_inReady  <= 1'b0;
            r_state    <= DIV;
          end
        end
        DIV: begin
          if (r_divisor == '0) begin
            r_q        <= w_allOnes;
            r_holds    <= w_holdsZero;
            r_divZero  <= 1'b1;
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_rem  <= w_remNext;
            r_quot <= w_quotNext;
            if (r_bitCnt == '0) begin
              r_q        <= w_quotNext;
              r_holds    <= w_holdsNext;
              r_divZero  <= 1'b0;
              r_outValid <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_bitCnt <= r_bitCnt - 1'b1;
            end
          end
        end
        DONE: begin
          // in_ready only rises here, so no accept can share the handshake edge.
          if (bus.out_ready) begin
            if (r_holds) begin
              if (r_passCnt != {CNT_W{1'b1}}) r_passCnt <= r_passCnt + 1'b1;
            end else begin
              if (r_failCnt != {CNT_W{1'b1}}) r_failCnt <= r_failCnt + 1'b1;
            end
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.q         = r_q;
  assign bus.holds     = r_holds;
  assign bus.div_zero  = r_divZero;
  assign bus.pass_cnt  = r_passCnt;
  assign bus.fail_cnt  = r_failCnt;

endmodule

// File: tb/tb_ic_bvsle_bvudiv_witness_checker.sv
// Testbench for ic_bvsle_bvudiv_witness_checker (W=4).
// Two checkers run in lockstep on the same requests: one with 16-bit counters
// and one with 2-bit counters so that counter saturation is observable.
// Expected results come from a vector table and pass through a scoreboard
// queue between the accept edge and the result handshake.
module tb_ic_bvsle_bvudiv_witness_checker;

  logic clk;
  logic rst_n;

  ic_bvsle_bvudiv_witness_checker_if #(.W(4), .CNT_W(16)) bus ();
  ic_bvsle_bvudiv_witness_checker_if #(.W(4), .CNT_W(2))  bus2 ();

  ic_bvsle_bvudiv_witness_checker #(.W(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ic_bvsle_bvudiv_witness_checker #(.W(4), .CNT_W(2)) dutSat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  // The saturating instance sees exactly the same request/result traffic.
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.op_sel    = bus.op_sel;
  assign bus2.x         = bus.x;
  assign bus2.s         = bus.s;
  assign bus2.t         = bus.t;
  assign bus2.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       opSel;
    logic [3:0] x;
    logic [3:0] s;
    logic [3:0] t;
    logic [3:0] expQ;
    logic       expHolds;
    logic       expDz;
    int         expLat;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic       holds;
    logic       dz;
  } exp_t;

  vec_t vecs [12];
  exp_t sbQ [$];

  int   nCompared;
  int   nMismatched;
  int   expPass;
  int   expFail;
  logic lastHolds;

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic boundExpired(input string name);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Present a request and hold it until accepted; waitCycles reports how many
  // extra cycles in_ready stayed low before the accept edge.
  task automatic applyStimulus(input vec_t v, output int waitCycles);
    @(negedge clk);
    bus.op_sel   = v.opSel;
    bus.x        = v.x;
    bus.s        = v.s;
    bus.t        = v.t;
    bus.in_valid = 1'b1;
    waitCycles   = 0;
    while (!bus.in_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!bus.in_ready) begin
      boundExpired("accept");
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      sbQ.push_back('{v.expQ, v.expHolds, v.expDz});
      #1;
      bus.in_valid = 1'b0;
      bus.x        = ~v.x;
      bus.s        = ~v.s;
      bus.t        = ~v.t;
      bus.op_sel   = ~v.opSel;
    end
  endtask

  task automatic waitResult(input int expLat);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 20);
    if (!bus.out_valid) boundExpired("out_valid");
    else check("latency", lat, expLat);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbQ.size() == 0) begin
      boundExpired("scoreboard_empty");
    end else begin
      e = sbQ.pop_front();
      check("q", bus.q, e.q);
      check("holds", bus.holds, e.holds);
      check("div_zero", bus.div_zero, e.dz);
      check("q_sat_inst", bus2.q, e.q);
      lastHolds = e.holds;
    end
  endtask

  // Result handshake followed by counter and ready/valid checks.
  task automatic consume();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    if (lastHolds) expPass++;
    else expFail++;
    check("pass_cnt", bus.pass_cnt, expPass);
    check("fail_cnt", bus.fail_cnt, expFail);
    check("pass_cnt_sat", bus2.pass_cnt, sat3(expPass));
    check("fail_cnt_sat", bus2.fail_cnt, sat3(expFail));
    check("out_valid_after_hs", bus.out_valid, 0);
    check("in_ready_after_hs", bus.in_ready, 1);
  endtask

  task automatic runVec(input vec_t v);
    int w;
    applyStimulus(v, w);
    waitResult(v.expLat);
    checkOutput();
    consume();
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_q"}, bus.q, 0);
    check({tag, "_holds"}, bus.holds, 0);
    check({tag, "_div_zero"}, bus.div_zero, 0);
    check({tag, "_pass_cnt"}, bus.pass_cnt, 0);
    check({tag, "_fail_cnt"}, bus.fail_cnt, 0);
    check({tag, "_pass_cnt_sat"}, bus2.pass_cnt, 0);
  endtask

  initial begin
    int w;
    nCompared     = 0;
    nMismatched   = 0;
    expPass       = 0;
    expFail       = 0;
    lastHolds     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_sel    = 1'b0;
    bus.x         = '0;
    bus.s         = '0;
    bus.t         = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;

    //          opSel x      s      t      q      holds dz    lat
    vecs[0]  = '{1'b0, 4'd13, 4'd3,  4'd4,  4'd4,  1'b1, 1'b0, 4};
    vecs[1]  = '{1'b0, 4'd13, 4'd3,  4'd3,  4'd4,  1'b0, 1'b0, 4};
    vecs[2]  = '{1'b1, 4'd3,  4'd2,  4'h8,  4'd0,  1'b0, 1'b0, 4};
    vecs[3]  = '{1'b0, 4'd15, 4'd1,  4'h7,  4'hF,  1'b1, 1'b0, 4};
    vecs[4]  = '{1'b0, 4'd9,  4'd0,  4'h0,  4'hF,  1'b1, 1'b1, 1};
    vecs[5]  = '{1'b1, 4'd0,  4'd5,  4'h8,  4'hF,  1'b0, 1'b1, 1};
    vecs[6]  = '{1'b0, 4'd7,  4'd2,  4'd3,  4'd3,  1'b1, 1'b0, 4};
    vecs[7]  = '{1'b0, 4'd15, 4'd15, 4'd0,  4'd1,  1'b0, 1'b0, 4};
    vecs[8]  = '{1'b1, 4'd4,  4'd12, 4'hB,  4'd3,  1'b0, 1'b0, 4};
    vecs[9]  = '{1'b0, 4'd8,  4'd3,  4'd2,  4'd2,  1'b1, 1'b0, 4};
    vecs[10] = '{1'b0, 4'd14, 4'd4,  4'hF,  4'd3,  1'b0, 1'b0, 4};
    vecs[11] = '{1'b0, 4'd12, 4'd1,  4'hC,  4'hC,  1'b1, 1'b0, 4};

    #12;
    checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      runVec(vecs[i]);
    end

    // Backpressure: result held with a new request waiting the whole time.
    $display("[TB] backpressure sequence");
    applyStimulus(vecs[0], w);
    waitResult(vecs[0].expLat);
    @(negedge clk);
    bus.op_sel   = vecs[1].opSel;
    bus.x        = vecs[1].x;
    bus.s        = vecs[1].s;
    bus.t        = vecs[1].t;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_q", bus.q, vecs[0].expQ);
      check("bp_holds", bus.holds, vecs[0].expHolds);
      check("bp_pass_cnt", bus.pass_cnt, expPass);
      check("bp_fail_cnt", bus.fail_cnt, expFail);
    end
    checkOutput();
    consume();
    applyStimulus(vecs[1], w);
    check("accept_after_release", w, 0);
    waitResult(vecs[1].expLat);
    checkOutput();
    consume();

    // Asynchronous reset after two divide steps.
    $display("[TB] reset mid-divide sequence");
    applyStimulus(vecs[9], w);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    sbQ.delete();
    expPass = 0;
    expFail = 0;
    @(negedge clk);
    rst_n = 1'b1;
    runVec(vecs[6]);

    // Saturation of the 2-bit counters while the wide counters keep counting.
    $display("[TB] saturation sequence");
    for (int i = 0; i < 5; i++) begin
      runVec(vecs[0]);
    end
    check("sat_pass_cnt_final", bus2.pass_cnt, 3);
    check("wide_pass_cnt_final", bus.pass_cnt, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
